// File: rtl/rv32i_pkg.sv
// rv32i_pkg: constants and types shared by the RV32I front end.
//  XLEN/ILEN         : data and instruction widths
//  RESET_PC_DEFAULT  : default PC of the first fetch after reset
//  NOP               : canonical ADDI x0,x0,0 encoding
//  OPC_*             : base opcodes, shared with the control unit
//  fetch_entry_t     : {pc, instr} record carried through the fetch buffer
//  align_word()      : clears the byte offset of an address
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP              = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO holding fetched {pc, instr} words in order.
//  clk, rst      : clock, asynchronous active-high reset
//  push/push_data: write an entry (accepted when not full, or full with pop)
//  pop           : drop the head entry (ignored when empty)
//  flush         : empty the FIFO; dominates push and pop
//  head_data     : current head entry (undefined contents when empty)
//  full/empty    : occupancy flags
//  count         : number of valid entries
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  assign do_push   = push && (!full || pop);
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr_q];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // NOTE: storage is deliberately not reset; count/pointers alone decide
  // validity, and the top masks the head while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_q] <= push_data;
  end

  // NOTE: state registers take non-blocking assignments only, so every
  // always_ff in this design sees the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: RV32I instruction fetch stage feeding decode/control.
//  clk, rst                      : clock, asynchronous active-high reset
//  imem_req_valid/ready/addr     : word read request to instruction memory
//  imem_resp_valid/data          : in-order read data from memory
//  redirect_valid/redirect_pc    : branch/jump target, flushes in-flight work
//  instr_valid/ready             : handshake toward decode
//  instruction/instr_pc          : fetched word and its address
// Outstanding requests plus buffered words never exceed FIFO_DEPTH, so a
// returning word always has a free buffer slot. Responses to requests issued
// before a redirect are counted in `discard` and dropped as they arrive.
module instr_fetch
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW:0]     in_use;

  logic            req_fire, resp_fire, resp_drop;
  logic            fifo_push, fifo_pop;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;
  fetch_entry_t    push_entry, head_entry;

  // Credits: requests in flight plus words already buffered.
  assign in_use = {1'b0, outstanding_q} + {1'b0, fifo_count};

  // rst gates the request combinationally so nothing issues while reset is
  // held, even though the counters already read zero.
  assign imem_req_valid = !rst && !redirect_valid && (in_use < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc_q;

  assign req_fire  = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_fire = imem_resp_valid && (outstanding_q != '0);
  assign resp_drop = resp_fire && (discard_q != '0);

  // A live response arriving with a redirect is stale too, so it is dropped.
  assign fifo_push  = resp_fire && !resp_drop && !redirect_valid;
  assign fifo_pop   = instr_valid && instr_ready && !redirect_valid;
  assign push_entry = '{pc: pc_of_resp(), instr: imem_resp_data};

  // PC of a returning word: the oldest in-flight address. Kept in a small
  // address queue alongside the outstanding counter.
  logic [XLEN-1:0] addr_q [FIFO_DEPTH];
  logic [$clog2(FIFO_DEPTH)-1:0] aq_wr_q, aq_rd_q;

  function automatic logic [XLEN-1:0] pc_of_resp();
    return addr_q[aq_rd_q];
  endfunction

  function automatic logic [$clog2(FIFO_DEPTH)-1:0] aq_inc(
    input logic [$clog2(FIFO_DEPTH)-1:0] p
  );
    return (p == ($clog2(FIFO_DEPTH))'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (req_fire) addr_q[aq_wr_q] <= pc_q;
  end

  // The address queue mirrors the outstanding count, including requests that
  // will be discarded, so it is never flushed by a redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aq_wr_q <= '0;
      aq_rd_q <= '0;
    end else begin
      if (req_fire)  aq_wr_q <= aq_inc(aq_wr_q);
      if (resp_fire) aq_rd_q <= aq_inc(aq_rd_q);
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path
  // through the block leaves a value held and no latch is inferred.
  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_fire);
    discard_d     = discard_q;
    if (redirect_valid) begin
      pc_d      = align_word(redirect_pc);
      // Everything still in flight after this edge belongs to the old path.
      discard_d = outstanding_d;
    end else begin
      if (req_fire)  pc_d      = pc_q + 32'd4;
      if (resp_drop) discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Outputs come straight from the buffer head, zeroed while it is empty.
  assign instr_valid = !fifo_empty;
  assign instruction = fifo_empty ? '0 : head_entry.instr;
  assign instr_pc    = fifo_empty ? '0 : head_entry.pc;

  a_no_resp_without_request: assert property (
    @(posedge clk) disable iff (rst) !(imem_resp_valid && outstanding_q == '0));

  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (rst) !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch with a latency-configurable
// in-order memory model and a scoreboard of expected {pc, instr} words.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;

  instr_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instruction     (instruction),
    .instr_pc        (instr_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] data;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  pend_t       pend_q[$];
  exp_t        exp_q[$];
  logic [31:0] acc_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int base = 0;
  int lat = 1;

  logic        rst_v, rdy_v, irdy_v, redir_v;
  logic [31:0] redir_pc_v;

  logic        s_req_valid, s_instr_valid;
  logic [31:0] s_addr, s_instr_pc;
  int          s_cyc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, sample 1 ns later,
  // and record what the next rising edge will commit.
  task automatic cycle();
    @(negedge clk);
    rst            = rst_v;
    imem_req_ready = rdy_v;
    instr_ready    = irdy_v;
    redirect_valid = redir_v;
    redirect_pc    = redir_pc_v;
    if (!rst_v && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = pend_q[0].data;
      void'(pend_q.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
    #1;
    s_req_valid   = imem_req_valid;
    s_addr        = imem_req_addr;
    s_instr_valid = instr_valid;
    s_instr_pc    = instr_pc;
    s_cyc         = cyc;
    if (rst_v) begin
      pend_q.delete();
      exp_q.delete();
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        pend_q.push_back('{data: mem_word(imem_req_addr), due: cyc + lat});
        exp_q.push_back('{pc: imem_req_addr, instr: mem_word(imem_req_addr)});
        acc_q.push_back(imem_req_addr);
      end
      if (redir_v) begin
        check("req_suppressed_on_redirect", {31'b0, imem_req_valid}, 32'd0);
        exp_q.delete();
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst_v = 1'b1;
    repeat (2) cycle();
    rst_v = 1'b0;
    base  = cyc;
    acc_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"},   {31'b0, imem_req_valid}, 32'd0);
    check({tag, "_req_addr"},    imem_req_addr, 32'h0);
    check({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'd0);
    check({tag, "_instruction"}, instruction, 32'h0);
    check({tag, "_instr_pc"},    instr_pc, 32'h0);
  endtask

  // Monitor: every word decode consumes must be the next expected one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && instr_valid && instr_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_word: got pc %h instr %h, expected none", instr_pc, instruction);
        end else begin
          e = exp_q.pop_front();
          check("mon_instr_pc", instr_pc, e.pc);
          check("mon_instruction", instruction, e.instr);
        end
      end
    end
  end

  initial begin
    int          first_idx;
    logic        found;
    logic [31:0] first_pc;

    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    rst_v = 1'b1; rdy_v = 1'b1; irdy_v = 1'b1; redir_v = 1'b0; redir_pc_v = '0;

    // Reset state
    cycle();
    check_reset_outputs("reset");

    // 1: streaming fetch, 1-cycle memory
    do_reset();
    lat = 1; rdy_v = 1'b1; irdy_v = 1'b1;
    first_idx = -1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (s_instr_valid && first_idx < 0) first_idx = s_cyc - base;
    end
    check("t1_first_valid_cycle", first_idx, 32'd2);
    check("t1_acc_count_ge4", {31'b0, acc_q.size() >= 4}, 32'd1);
    for (int i = 0; i < 4; i++)
      if (i < acc_q.size()) check("t1_req_addr", acc_q[i], 32'(i * 4));

    // 2: decode stalled from the start -> credits stop fetch after two
    do_reset();
    irdy_v = 1'b0;
    repeat (8) cycle();
    check("t2_accept_count", acc_q.size(), 32'd2);
    check("t2_req_valid_stalled", {31'b0, s_req_valid}, 32'd0);
    check("t2_instr_valid", {31'b0, s_instr_valid}, 32'd1);
    check("t2_head_pc", s_instr_pc, 32'h0);
    irdy_v = 1'b1;
    acc_q.delete();
    repeat (6) cycle();
    check("t2_resume_nonempty", {31'b0, acc_q.size() > 0}, 32'd1);
    if (acc_q.size() > 0) check("t2_resume_addr", acc_q[0], 32'h8);

    // 3: redirect with two slow requests in flight
    do_reset();
    lat = 3;
    repeat (2) cycle();
    check("t3_two_outstanding", acc_q.size(), 32'd2);
    redir_v = 1'b1; redir_pc_v = 32'h100;
    cycle();
    redir_v = 1'b0;
    acc_q.delete();
    found = 1'b0; first_pc = '0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (s_instr_valid && !found) begin found = 1'b1; first_pc = s_instr_pc; end
    end
    check("t3_found", {31'b0, found}, 32'd1);
    check("t3_first_pc", first_pc, 32'h100);
    if (acc_q.size() > 0) check("t3_first_req", acc_q[0], 32'h100);

    // 4: redirect in the cycle decode pops and a live response arrives
    do_reset();
    lat = 1;
    repeat (2) cycle();
    redir_v = 1'b1; redir_pc_v = 32'h40;
    cycle();
    check("t4_valid_at_redirect", {31'b0, s_instr_valid}, 32'd1);
    redir_v = 1'b0;
    cycle();
    check("t4_valid_after_redirect", {31'b0, s_instr_valid}, 32'd0);
    found = 1'b0; first_pc = '0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (s_instr_valid && !found) begin found = 1'b1; first_pc = s_instr_pc; end
    end
    check("t4_found", {31'b0, found}, 32'd1);
    check("t4_first_pc", first_pc, 32'h40);

    // 5: misaligned target, back-to-back redirect, PC wrap
    do_reset();
    lat = 3;
    repeat (3) cycle();
    redir_v = 1'b1; redir_pc_v = 32'h203;
    cycle();
    redir_pc_v = 32'hFFFF_FFFC;
    cycle();
    check("t5_aligned_addr", s_addr, 32'h200);
    redir_v = 1'b0;
    acc_q.delete();
    repeat (12) cycle();
    check("t5_accepts_ge2", {31'b0, acc_q.size() >= 2}, 32'd1);
    if (acc_q.size() >= 2) begin
      check("t5_addr_top", acc_q[0], 32'hFFFF_FFFC);
      check("t5_addr_wrap", acc_q[1], 32'h0);
    end

    // 6: asynchronous reset with two requests in flight
    do_reset();
    lat = 3;
    repeat (2) cycle();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    pend_q.delete();
    exp_q.delete();
    rst_v = 1'b1;
    repeat (2) cycle();
    rst_v = 1'b0;
    acc_q.delete();
    lat = 1;
    repeat (8) cycle();
    check("t6_restart_nonempty", {31'b0, acc_q.size() > 0}, 32'd1);
    if (acc_q.size() > 0) check("t6_restart_addr", acc_q[0], 32'h0);

    // Drain: every expected word must have reached decode.
    rdy_v = 1'b0; irdy_v = 1'b1;
    repeat (10) cycle();
    check("drain_scoreboard_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
